d_sram_like_bridge_wbuf: RTL and testbench

//  Data-side bridge: CPU SRAM-style port to SRAM-like bus (req/addr_ok/data_ok), one bus transaction in flight.

---
 rtl/d_bridge_pkg.sv | 29 ++
 rtl/wbuf_fifo.sv | 73 +++++++
 rtl/d_sram_like_bridge_wbuf.sv | 171 +++++++++++++++++
 tb/tb_d_sram_like_bridge_wbuf.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_bridge_pkg.sv
// Shared types and helpers for the data-side SRAM-like bridge with posted-write buffer.
package d_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } bus_state_t;

    localparam int BUS_DATA_W = 32;
    localparam int BYTES      = BUS_DATA_W / 8;
    localparam int MAX_BYTES  = 8;

    // Byte-enable popcount mapped to log2(bytes); unexpected patterns fall back to word size.
    function automatic logic [1:0] size_enc(input logic [MAX_BYTES-1:0] wen);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            cnt += int'(wen[i]);
        end
        case (cnt)
            1:       size_enc = 2'd0;
            2:       size_enc = 2'd1;
            8:       size_enc = 2'd3;
            default: size_enc = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: DEPTH entries of {addr, wdata, wen}, head visible without popping.
module wbuf_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                push,
    input  logic                pop,
    input  logic [ADDR_W-1:0]   push_addr,
    input  logic [DATA_W-1:0]   push_wdata,
    input  logic [DATA_W/8-1:0] push_wen,
    output logic                full,
    output logic                empty,
    output logic [ADDR_W-1:0]   head_addr,
    output logic [DATA_W-1:0]   head_wdata,
    output logic [DATA_W/8-1:0] head_wen
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]     addr_mem_q  [DEPTH];
    logic [ADDR_W-1:0]     addr_mem_d  [DEPTH];
    logic [DATA_W-1:0]     wdata_mem_q [DEPTH];
    logic [DATA_W-1:0]     wdata_mem_d [DEPTH];
    logic [DATA_W/8-1:0]   wen_mem_q   [DEPTH];
    logic [DATA_W/8-1:0]   wen_mem_d   [DEPTH];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        addr_mem_d  = addr_mem_q;
        wdata_mem_d = wdata_mem_q;
        wen_mem_d   = wen_mem_q;
        if (push) begin
            addr_mem_d[wr_ptr_q[PTR_W-1:0]]  = push_addr;
            wdata_mem_d[wr_ptr_q[PTR_W-1:0]] = push_wdata;
            wen_mem_d[wr_ptr_q[PTR_W-1:0]]   = push_wen;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        addr_mem_q  <= addr_mem_d;
        wdata_mem_q <= wdata_mem_d;
        wen_mem_q   <= wen_mem_d;
    end

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_addr  = addr_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_wdata = wdata_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_wen   = wen_mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/d_sram_like_bridge_wbuf.sv
// Data-side bridge from the CPU SRAM port to an SRAM-like bus, one transaction in flight,
// with stores retired into a posted-write buffer that drains ahead of any load.
module d_sram_like_bridge_wbuf
    import d_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                longest_stall,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                d_stall,
    output logic                wbuf_empty,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W-1:0]   data_rdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok
);

    localparam int NBYTES = DATA_W / 8;
    localparam logic [1:0] LOAD_SIZE = (NBYTES == 8) ? 2'd3 : 2'd2;

    bus_state_t          state_q, state_d;
    logic                src_wbuf_q, src_wbuf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                done_q, done_d;
    logic                discard_q, discard_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                fifo_full, fifo_empty;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_wdata;
    logic [NBYTES-1:0]   head_wen;
    logic [MAX_BYTES-1:0] head_wen_ext;

    logic is_store, is_load, push, pop, issue_wbuf, issue_load, complete;

    assign is_store   = data_sram_en & (|data_sram_wen);
    assign is_load    = data_sram_en & ~(|data_sram_wen);
    assign push       = is_store & ~flush & ~fifo_full;
    assign issue_wbuf = ~fifo_empty;
    assign issue_load = is_load & fifo_empty & ~done_q & ~flush;
    assign complete   = ((state_q == ADDR) & data_addr_ok & data_data_ok) |
                        ((state_q == DATA) & data_data_ok);
    assign pop        = complete & src_wbuf_q;

    wbuf_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WB_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .pop        (pop),
        .push_addr  (data_sram_addr),
        .push_wdata (data_sram_wdata),
        .push_wen   (data_sram_wen),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_addr  (head_addr),
        .head_wdata (head_wdata),
        .head_wen   (head_wen)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (issue_wbuf || issue_load) state_d = ADDR;
            ADDR: if (data_addr_ok) state_d = data_data_ok ? IDLE : DATA;
            DATA: if (data_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_req   = (state_q == ADDR);
        data_wr    = src_wbuf_q;
        data_size  = size_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        wbuf_empty = fifo_empty & (state_q == IDLE);
        d_stall    = (is_store & fifo_full) | (is_load & ~done_q);
    end

    // Bus fields are captured on issue so a flushed CPU port cannot disturb a held request.
    always_comb begin
        head_wen_ext             = '0;
        head_wen_ext[NBYTES-1:0] = head_wen;
        src_wbuf_d = src_wbuf_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        if (state_q == IDLE) begin
            if (issue_wbuf) begin
                src_wbuf_d = 1'b1;
                addr_d     = head_addr;
                wdata_d    = head_wdata;
                size_d     = size_enc(head_wen_ext);
            end else if (issue_load) begin
                src_wbuf_d = 1'b0;
                addr_d     = data_sram_addr;
                wdata_d    = '0;
                size_d     = LOAD_SIZE;
            end
        end
    end

    // A flushed load still completes on the bus, but its data must never reach the pipeline.
    always_comb begin
        done_d    = done_q;
        discard_d = discard_q;
        rdata_d   = rdata_q;
        if (done_q && !longest_stall) done_d = 1'b0;
        if (complete && !src_wbuf_q) begin
            if (discard_q || flush) begin
                discard_d = 1'b0;
            end else begin
                rdata_d = data_rdata;
                done_d  = 1'b1;
            end
        end else if (flush && !src_wbuf_q && state_q != IDLE) begin
            discard_d = 1'b1;
        end
        if (flush) done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            src_wbuf_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'd0;
            done_q     <= 1'b0;
            discard_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            src_wbuf_q <= src_wbuf_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            done_q     <= done_d;
            discard_q  <= discard_d;
            rdata_q    <= rdata_d;
        end
    end

    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_d_sram_like_bridge_wbuf.sv
// Directed self-checking bench for d_sram_like_bridge_wbuf: stores, buffering, loads, flush, reset.
module tb_d_sram_like_bridge_wbuf;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        longest_stall;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        wbuf_empty;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_addr [8];

    d_sram_like_bridge_wbuf #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .WB_DEPTH (4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .longest_stall   (longest_stall),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .wbuf_empty      (wbuf_empty),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_rdata      (data_rdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_store(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    task automatic cpu_load(input logic [31:0] addr);
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'h0;
        data_sram_addr  = addr;
        data_sram_wdata = 32'h0;
    endtask

    task automatic cpu_idle();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
    endtask

    // Answer every request immediately until the buffer is drained; every request must be a write.
    task automatic drain(input int exp_writes);
        int n;
        n = 0;
        for (int i = 0; i < 60 && !wbuf_empty; i++) begin
            if (data_req) begin
                check_output("drain_addr", data_addr, exp_addr[n]);
                check_output("drain_wr", data_wr, 1'b1);
                n++;
                data_addr_ok = 1'b1;
                data_data_ok = 1'b1;
            end else begin
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
            end
            tick();
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        check_output("drain_empty", wbuf_empty, 1'b1);
        check_output("drain_count", n, exp_writes);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; longest_stall = 1'b0;
        data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        data_rdata = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0;

        // Reset state
        tick(); tick();
        #1;
        check_output("rst_req", data_req, 1'b0);
        check_output("rst_rdata", data_sram_rdata, 32'h0);
        check_output("rst_wbuf_empty", wbuf_empty, 1'b1);
        check_output("rst_stall", d_stall, 1'b0);
        resetn = 1'b1;
        tick();

        // Single word store
        cpu_store(32'h100, 4'hF, 32'h1111_2222);
        #1 check_output("sw_stall", d_stall, 1'b0);
        tick();
        cpu_idle();
        #1;
        check_output("sw_wbuf_busy", wbuf_empty, 1'b0);
        check_output("sw_req_idle", data_req, 1'b0);
        tick();
        #1;
        check_output("sw_req", data_req, 1'b1);
        check_output("sw_wr", data_wr, 1'b1);
        check_output("sw_size", data_size, 2'd2);
        check_output("sw_addr", data_addr, 32'h100);
        check_output("sw_wdata", data_wdata, 32'h1111_2222);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check_output("sw_done_req", data_req, 1'b0);
        check_output("sw_done_empty", wbuf_empty, 1'b1);

        // Fill buffer with addr_ok held low; fifth store stalls until first completion
        cpu_store(32'h300, 4'hF, 32'h3000_0000);
        #1 check_output("fill0_stall", d_stall, 1'b0);
        tick();
        cpu_store(32'h304, 4'hF, 32'h3000_0004);
        tick();
        cpu_store(32'h308, 4'hF, 32'h3000_0008);
        tick();
        cpu_store(32'h30C, 4'hF, 32'h3000_000C);
        tick();
        cpu_store(32'h310, 4'hF, 32'h3000_0010);
        #1 check_output("fill4_stall", d_stall, 1'b1);
        tick();
        #1;
        check_output("fill4_stall_hold", d_stall, 1'b1);
        check_output("fill_head_addr", data_addr, 32'h300);
        check_output("fill_head_req", data_req, 1'b1);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        #1 check_output("fill4_stall_popcycle", d_stall, 1'b1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1 check_output("fill4_accept", d_stall, 1'b0);
        tick();
        cpu_idle();
        exp_addr[0] = 32'h304; exp_addr[1] = 32'h308; exp_addr[2] = 32'h30C; exp_addr[3] = 32'h310;
        drain(4);

        // Store then load to the same address: load waits for the store to finish
        cpu_store(32'h200, 4'hF, 32'hAAAA_5555);
        #1 check_output("raw_store_stall", d_stall, 1'b0);
        tick();
        cpu_load(32'h200);
        #1 check_output("raw_load_stall", d_stall, 1'b1);
        tick();
        #1;
        check_output("raw_st_req", data_req, 1'b1);
        check_output("raw_st_wr", data_wr, 1'b1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1 check_output("raw_st_data_phase_req", data_req, 1'b0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        check_output("raw_ld_not_yet", data_req, 1'b0);
        check_output("raw_ld_stall", d_stall, 1'b1);
        tick();
        #1;
        check_output("raw_ld_req", data_req, 1'b1);
        check_output("raw_ld_wr", data_wr, 1'b0);
        check_output("raw_ld_addr", data_addr, 32'h200);
        check_output("raw_ld_size", data_size, 2'd2);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check_output("raw_ld_stall_rel", d_stall, 1'b0);
        check_output("raw_ld_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        cpu_idle();
        tick();

        // Load completing under longest_stall: result held, no reissue
        cpu_load(32'h400);
        #1 check_output("ls_stall", d_stall, 1'b1);
        tick();
        #1;
        check_output("ls_req", data_req, 1'b1);
        check_output("ls_addr", data_addr, 32'h400);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; longest_stall = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("ls_hold_stall", d_stall, 1'b0);
            check_output("ls_hold_rdata", data_sram_rdata, 32'hCAFE_F00D);
            check_output("ls_hold_noreq", data_req, 1'b0);
            tick();
        end
        longest_stall = 1'b0;
        #1 check_output("ls_release_stall", d_stall, 1'b0);
        tick();
        cpu_idle();
        #1;
        check_output("ls_after_rdata", data_sram_rdata, 32'hCAFE_F00D);
        check_output("ls_after_noreq", data_req, 1'b0);
        tick();

        // Flush while a load is in its data phase; response dropped, stores still drain
        cpu_load(32'h500);
        tick();
        #1;
        check_output("fl_req", data_req, 1'b1);
        check_output("fl_addr", data_addr, 32'h500);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        #1 check_output("fl_data_phase_req", data_req, 1'b0);
        tick();
        flush = 1'b0;
        cpu_store(32'h600, 4'hF, 32'h6666_6666);
        #1 check_output("fl_store_stall", d_stall, 1'b0);
        tick();
        cpu_idle();
        data_data_ok = 1'b1; data_rdata = 32'h0000_1234;
        #1 check_output("fl_resp_req", data_req, 1'b0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1 check_output("fl_rdata_kept", data_sram_rdata, 32'hCAFE_F00D);
        cpu_load(32'h500);
        #1 check_output("fl_done_clear", d_stall, 1'b1);
        cpu_idle();
        exp_addr[0] = 32'h600;
        drain(1);

        // Byte and halfword stores, then reset while in the data phase
        cpu_store(32'h701, 4'h2, 32'h0000_AB00);
        tick();
        cpu_store(32'h702, 4'hC, 32'hCDEF_0000);
        tick();
        cpu_idle();
        #1;
        check_output("sb_req", data_req, 1'b1);
        check_output("sb_size", data_size, 2'd0);
        check_output("sb_addr", data_addr, 32'h701);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1 check_output("sb_gap_req", data_req, 1'b0);
        tick();
        #1;
        check_output("sh_req", data_req, 1'b1);
        check_output("sh_size", data_size, 2'd1);
        check_output("sh_addr", data_addr, 32'h702);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1 check_output("sh_data_phase_busy", wbuf_empty, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check_output("mid_rst_req", data_req, 1'b0);
        check_output("mid_rst_empty", wbuf_empty, 1'b1);
        check_output("mid_rst_rdata", data_sram_rdata, 32'h0);
        tick();
        #1;
        check_output("mid_rst_noreplay", data_req, 1'b0);
        check_output("mid_rst_empty2", wbuf_empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
